// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter: SLL, SRL, SRA, ROL, ROR and pass-through.
// Each stage registers one shift layer. Stage 0 handles WIDTH/2 and the last
// stage handles a shift of 1. A single global stall holds the whole pipe.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready = !stall, combinational)
//   in_data/in_shamt   operand and shift amount 0..WIDTH-1
//   in_op              000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass
//   out_valid/out_ready output handshake
//   out_data/out_zero  registered result and its zero flag
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // One shift layer of weight amt; en is the shamt bit for that weight.
  function automatic logic [WIDTH-1:0] layer(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             en,
    input logic             sign,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] fill;
    fill  = ~({WIDTH{1'b1}} >> amt) & {WIDTH{sign}};
    layer = d;
    if (en) begin
      case (op)
        OP_SLL:  layer = d << amt;
        OP_SRL:  layer = d >> amt;
        OP_SRA:  layer = (d >> amt) | fill;
        OP_ROL:  layer = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:  layer = (d >> amt) | (d << (WIDTH - amt));
        default: layer = d;
      endcase
    end
  endfunction

  logic stall_c;
  logic zero_q, zero_d;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    // BIT is the shamt bit this stage consumes; AMT its weight.
    localparam int unsigned BIT = SHW - 1 - k;
    localparam int unsigned AMT = 1 << BIT;

    logic [WIDTH-1:0] src_data;
    logic [2:0]       src_op;
    logic             src_sign;
    logic             src_valid;
    logic             src_en;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    if (k == 0) begin : g_src
      assign src_data  = in_data;
      assign src_op    = in_op;
      assign src_sign  = in_data[WIDTH-1];
      assign src_valid = in_valid && in_ready;
      assign src_en    = in_shamt[BIT];
    end else begin : g_src
      assign src_data  = g_stage[k-1].data_q;
      assign src_op    = g_stage[k-1].g_fwd.op_q;
      assign src_sign  = g_stage[k-1].g_fwd.sign_q;
      assign src_valid = g_stage[k-1].valid_q;
      assign src_en    = g_stage[k-1].g_fwd.shamt_q[BIT];
    end

    // Data and valid advance together unless the pipe is stalled.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (!stall_c) begin
        data_d  = layer(src_data, src_op, src_en, src_sign, AMT);
        valid_d = src_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    // Control forwarded to later stages; only the shamt bits still needed travel on.
    if (k < SHW - 1) begin : g_fwd
      logic [2:0]     op_q, op_d;
      logic           sign_q, sign_d;
      logic [BIT-1:0] shamt_q, shamt_d;
      logic [BIT-1:0] src_rem;

      if (k == 0) begin : g_rem
        assign src_rem = in_shamt[BIT-1:0];
      end else begin : g_rem
        assign src_rem = g_stage[k-1].g_fwd.shamt_q[BIT-1:0];
      end

      always_comb begin
        op_d    = op_q;
        sign_d  = sign_q;
        shamt_d = shamt_q;
        if (!stall_c) begin
          op_d    = src_op;
          sign_d  = src_sign;
          shamt_d = src_rem;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          op_q    <= '0;
          sign_q  <= 1'b0;
          shamt_q <= '0;
        end else begin
          op_q    <= op_d;
          sign_q  <= sign_d;
          shamt_q <= shamt_d;
        end
      end
    end
  end

  assign out_valid = g_stage[SHW-1].valid_q;
  assign out_data  = g_stage[SHW-1].data_q;
  assign stall_c   = out_valid && !out_ready;
  assign in_ready  = !stall_c;
  assign out_zero  = zero_q;

  // Zero flag is registered alongside the last stage and only set for valid results.
  always_comb begin
    zero_d = zero_q;
    if (!stall_c) begin
      zero_d = g_stage[SHW-1].valid_d && (g_stage[SHW-1].data_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
  localparam int unsigned W   = 32;
  localparam int unsigned SW  = 5;
  localparam int unsigned W8  = 8;
  localparam int unsigned SW8 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;
  logic [2:0]    in_op;

  logic           w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_out_zero;
  logic [W8-1:0]  w8_in_data, w8_out_data;
  logic [SW8-1:0] w8_in_shamt;
  logic [2:0]     w8_in_op;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data),
    .in_shamt(w8_in_shamt), .in_op(w8_in_op),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .out_data(w8_out_data), .out_zero(w8_out_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word shift/rotate in one step.
  function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [2:0] op,
                                            input logic [4:0] s);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      3'd0:    return d << s;
      3'd1:    return d >> s;
      3'd2:    return 32'($signed(d) >>> s);
      3'd3:    return 32'((dd << s) >> 32);
      3'd4:    return 32'(dd >> s);
      default: return d;
    endcase
  endfunction

  // Single operation on an idle pipe: latency, data and zero flag.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [2:0] op,
                         input logic [4:0] s, input logic [31:0] exp);
    int lat;
    in_data  = d;
    in_op    = op;
    in_shamt = s;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(SW));
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    check({tag, "_zero"}, 64'(out_zero), 64'(exp == 32'h0));
    cyc();
  endtask

  logic [31:0] exp_q[$];

  initial begin
    int sent, got, stall_left, lat;
    bit stalled, seen;
    logic [31:0] rd;
    logic [2:0]  rop;
    logic [4:0]  rsh;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    w8_in_valid = 1'b0; w8_in_data = '0; w8_in_shamt = '0; w8_in_op = '0; w8_out_ready = 1'b1;
    repeat (3) cyc();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_zero", 64'(out_zero), 64'(0));
    check("rst_w8_out_valid", 64'(w8_out_valid), 64'(0));
    rst = 1'b0;
    cyc();
    check("idle_in_ready", 64'(in_ready), 64'(1));

    run_one("sra",     32'h8000_0000, 3'b010, 5'd4,  32'hF800_0000);
    run_one("ror",     32'h1234_5678, 3'b100, 5'd8,  32'h7812_3456);
    run_one("rol",     32'h8000_0001, 3'b011, 5'd1,  32'h0000_0003);
    run_one("srl31",   32'h8000_0000, 3'b001, 5'd31, 32'h0000_0001);
    run_one("sll31",   32'h0000_0001, 3'b000, 5'd31, 32'h8000_0000);
    run_one("sll0",    32'hFFFF_FFFF, 3'b000, 5'd0,  32'hFFFF_FFFF);
    run_one("srl_z",   32'h0000_000F, 3'b001, 5'd4,  32'h0000_0000);
    run_one("pass111", 32'hDEAD_BEEF, 3'b111, 5'd13, 32'hDEAD_BEEF);

    // Back-to-back random stream with a 3-cycle stall once the pipe is full.
    sent = 0; got = 0; stall_left = 0; stalled = 1'b0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      if (!stalled && out_valid) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (sent < 20) begin
        rd  = $urandom;
        rop = 3'($urandom_range(0, 7));
        rsh = 5'($urandom_range(0, 31));
        in_data = rd; in_op = rop; in_shamt = rsh; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_valid", 64'(out_valid), 64'(1));
        if (exp_q.size() > 0) check("stall_hold", 64'(out_data), 64'(exp_q[0]));
        stall_left--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_data, in_op, in_shamt));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 64'(out_valid), 64'(0));
        end else begin
          check("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
          got++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(got), 64'(20));
    check("stream_stalled", 64'(stalled), 64'(1));
    repeat (2) cyc();

    // Reset with three operations in flight: none may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h1111_1111 * (i + 1); in_op = 3'b000; in_shamt = 5'd1; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_data", 64'(out_data), 64'(0));
    check("midrst_out_zero", 64'(out_zero), 64'(0));
    seen = 1'b0;
    repeat (8) begin
      if (out_valid) seen = 1'b1;
      cyc();
    end
    check("midrst_no_stale", 64'(seen), 64'(0));
    run_one("post_rst", 32'h0000_0003, 3'b000, 5'd2, 32'h0000_000C);

    // WIDTH=8 instance.
    w8_in_data = 8'h90; w8_in_op = 3'b010; w8_in_shamt = 3'd3; w8_in_valid = 1'b1;
    cyc();
    w8_in_valid = 1'b0;
    lat = 1;
    while (!w8_out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check("w8_lat", 64'(lat), 64'(SW8));
    check("w8_data", 64'(w8_out_data), 64'(8'hF2));
    check("w8_zero", 64'(w8_out_zero), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
